// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale core: pipelined address/data phases,
// optional wait states, byte-enable stores and access-error reporting.
module vscale_dmem_responder #(
    parameter int unsigned WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic        dmem_wait,
    output logic [31:0] dmem_rdata,
    output logic        dmem_badmem_e
);
    // state  | meaning
    // S_IDLE | no data phase in progress
    // S_WAIT | data phase active, wait count nonzero, dmem_wait asserted
    // S_DATA | data phase completing this cycle
    localparam int         AW      = $clog2(WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_wait;
    logic        r_wen;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_mem [WORDS];

    logic          w_accept;
    logic          w_in_range;
    logic          w_misaligned;
    logic          w_bad;
    logic          w_commit;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;

    assign w_accept   = dmem_en && !r_wait;
    assign w_in_range = (r_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_idx      = r_addr[AW+1:2];
    assign w_bad      = !w_in_range || w_misaligned;
    assign w_commit   = (r_state == S_DATA) && r_wen && !w_bad && !reset;

    always_comb begin
        w_misaligned = 1'b1;
        w_be         = 4'b1111;
        case (r_size)
            3'd0: begin
                w_misaligned = 1'b0;
                w_be         = 4'b0001 << r_addr[1:0];
            end
            3'd1: begin
                w_misaligned = r_addr[0];
                w_be         = 4'b0011 << r_addr[1:0];
            end
            3'd2: begin
                w_misaligned = |r_addr[1:0];
                w_be         = 4'b1111;
            end
            default: begin
                w_misaligned = 1'b1;
                w_be         = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wait  <= 1'b0;
            r_wen   <= 1'b0;
            r_size  <= 3'd0;
            r_addr  <= 32'd0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DATA;
                        r_wait  <= 1'b0;
                    end
                end
                default: begin
                    // A new address phase is taken in IDLE or on the edge that ends DATA.
                    if (w_accept) begin
                        r_wen  <= dmem_wen;
                        r_size <= dmem_size;
                        r_addr <= dmem_addr;
                        r_cnt  <= WAIT_LD;
                        if (WAIT_LD != 4'd0) begin
                            r_state <= S_WAIT;
                            r_wait  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_wait  <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_wait  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Store commits at the edge ending DATA, so a read accepted on that edge sees the merged word.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= dmem_wdata_delayed[8*k +: 8];
                end
            end
        end
    end

    assign dmem_wait     = r_wait;
    assign dmem_badmem_e = (r_state == S_DATA) && w_bad;
    assign dmem_rdata    = ((r_state == S_DATA) && !r_wen && !w_bad) ? r_mem[w_idx] : 32'd0;
endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed bench for vscale_dmem_responder: one instance with no wait states,
// one with three, sharing the request bus and selected by sel3.
module tb_vscale_dmem_responder;
    logic        clk;
    logic        rst0, rst3;
    logic        sel3;
    logic        en, wen;
    logic [2:0]  size;
    logic [31:0] addr, wdata;

    logic        en0, en3;
    logic        w_wait0, w_wait3, w_bad0, w_bad3;
    logic [31:0] w_rdata0, w_rdata3;
    logic        w_wait, w_bad;
    logic [31:0] w_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    assign en0     = en & ~sel3;
    assign en3     = en & sel3;
    assign w_wait  = sel3 ? w_wait3  : w_wait0;
    assign w_bad   = sel3 ? w_bad3   : w_bad0;
    assign w_rdata = sel3 ? w_rdata3 : w_rdata0;

    vscale_dmem_responder #(.WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst0), .dmem_en(en0), .dmem_wen(wen), .dmem_size(size),
        .dmem_addr(addr), .dmem_wdata_delayed(wdata), .dmem_wait(w_wait0),
        .dmem_rdata(w_rdata0), .dmem_badmem_e(w_bad0)
    );

    vscale_dmem_responder #(.WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(rst3), .dmem_en(en3), .dmem_wen(wen), .dmem_size(size),
        .dmem_addr(addr), .dmem_wdata_delayed(wdata), .dmem_wait(w_wait3),
        .dmem_rdata(w_rdata3), .dmem_badmem_e(w_bad3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single non-pipelined access; junk is driven on wdata while the responder waits.
    task automatic access(input logic w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic bad, output int waits);
        en = 1'b1; wen = w; size = sz; addr = a;
        tick();
        en = 1'b0;
        wdata = 32'hBAD0_BAD0;
        waits = 0;
        while (w_wait && waits < 40) begin
            waits++;
            tick();
        end
        wdata = wd;
        #1;
        rd  = w_rdata;
        bad = w_bad;
        tick();
    endtask

    logic [31:0] rd;
    logic        bad;
    int          waits;

    initial begin
        rst0 = 1'b1; rst3 = 1'b1; sel3 = 1'b0;
        en = 1'b0; wen = 1'b0; size = 3'd2; addr = 32'd0; wdata = 32'd0;
        tick();
        tick();
        check("rst_wait0",  w_wait0,  0);
        check("rst_rdata0", w_rdata0, 0);
        check("rst_bad0",   w_bad0,   0);
        check("rst_wait3",  w_wait3,  0);
        check("rst_rdata3", w_rdata3, 0);
        check("rst_bad3",   w_bad3,   0);
        rst0 = 1'b0; rst3 = 1'b0;

        // Write then read of the same word back to back: forwarded value, no wait.
        en = 1'b1; wen = 1'b1; size = 3'd2; addr = 32'h10;
        tick();
        check("fwd_wdata_wait",  w_wait,  0);
        check("fwd_wdata_rdata", w_rdata, 0);
        wdata = 32'hDEAD_BEEF; wen = 1'b0;
        tick();
        check("fwd_read_wait",  w_wait,  0);
        check("fwd_read_rdata", w_rdata, 32'hDEAD_BEEF);
        en = 1'b0;
        tick();
        check("fwd_idle_rdata", w_rdata, 0);

        access(1'b1, 3'd2, 32'h10, 32'h1122_3344, rd, bad, waits);
        check("w0_waits", waits, 0);
        access(1'b1, 3'd0, 32'h13, 32'h5A5A_5A5A, rd, bad, waits);
        check("byte_wr_bad", bad, 0);
        access(1'b0, 3'd2, 32'h10, 32'h0, rd, bad, waits);
        check("byte_merge", rd, 32'h5A22_3344);

        access(1'b1, 3'd2, 32'h14, 32'h0, rd, bad, waits);
        access(1'b1, 3'd1, 32'h16, 32'hBEEF_BEEF, rd, bad, waits);
        access(1'b0, 3'd2, 32'h14, 32'h0, rd, bad, waits);
        check("half_merge", rd, 32'hBEEF_0000);

        access(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, rd, bad, waits);
        access(1'b0, 3'd1, 32'h21, 32'h0, rd, bad, waits);
        check("half_mis_bad",   bad, 1);
        check("half_mis_rdata", rd,  0);
        access(1'b1, 3'd2, 32'h22, 32'h0, rd, bad, waits);
        check("word_mis_bad", bad, 1);
        access(1'b0, 3'd2, 32'h20, 32'h0, rd, bad, waits);
        check("mis_target_kept", rd, 32'hCAFE_F00D);
        access(1'b0, 3'd0, 32'h23, 32'h0, rd, bad, waits);
        check("byte_rd_bad",  bad, 0);
        check("byte_rd_word", rd,  32'hCAFE_F00D);

        // Out-of-range read followed immediately by a valid pipelined read.
        en = 1'b1; wen = 1'b0; size = 3'd2; addr = 32'h1000;
        tick();
        check("oor_bad",   w_bad,   1);
        check("oor_rdata", w_rdata, 0);
        addr = 32'h20;
        tick();
        check("after_oor_bad",   w_bad,   0);
        check("after_oor_rdata", w_rdata, 32'hCAFE_F00D);
        en = 1'b0;
        tick();

        access(1'b0, 3'd3, 32'h20, 32'h0, rd, bad, waits);
        check("size3_bad",   bad, 1);
        check("size3_rdata", rd,  0);
        access(1'b1, 3'd2, 32'hFFC, 32'h0102_0304, rd, bad, waits);
        check("top_word_bad", bad, 0);
        access(1'b1, 3'd2, 32'h1010, 32'hFFFF_FFFF, rd, bad, waits);
        check("alias_wr_bad", bad, 1);
        access(1'b0, 3'd2, 32'h10, 32'h0, rd, bad, waits);
        check("no_alias", rd, 32'h5A22_3344);
        access(1'b0, 3'd2, 32'hFFC, 32'h0, rd, bad, waits);
        check("top_word_rd", rd, 32'h0102_0304);

        // Three-wait-state instance.
        sel3 = 1'b1;
        access(1'b1, 3'd2, 32'h10, 32'h1111_2222, rd, bad, waits);
        check("w3_wr_waits", waits, 3);
        access(1'b0, 3'd2, 32'h10, 32'h0, rd, bad, waits);
        check("w3_rd_waits", waits, 3);
        check("w3_rd_data",  rd,    32'h1111_2222);

        en = 1'b1; wen = 1'b0; size = 3'd2; addr = 32'h10;
        tick();
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("w3_wait_c%0d", i), w_wait, 1);
            check($sformatf("w3_rdata_c%0d", i), w_rdata, 0);
            tick();
        end
        check("w3_data_wait",  w_wait,  0);
        check("w3_data_rdata", w_rdata, 32'h1111_2222);
        tick();
        check("w3_next_accept", w_wait, 1);
        en = 1'b0;
        tick();
        tick();
        tick();
        check("w3_second_rdata", w_rdata, 32'h1111_2222);
        tick();
        check("w3_idle_rdata", w_rdata, 0);

        // Reset during the second wait cycle of a write aborts it.
        en = 1'b1; wen = 1'b1; size = 3'd2; addr = 32'h10; wdata = 32'h9999_9999;
        tick();
        en = 1'b0;
        tick();
        rst3 = 1'b1;
        tick();
        check("rstw_wait",  w_wait,  0);
        check("rstw_rdata", w_rdata, 0);
        check("rstw_bad",   w_bad,   0);
        rst3 = 1'b0; en = 1'b1; wen = 1'b0; addr = 32'h10;
        tick();
        check("rstw_accept", w_wait, 1);
        en = 1'b0;
        tick();
        tick();
        tick();
        check("rstw_retained", w_rdata, 32'h1111_2222);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vscale_dmem_responder.md
VSCALE_DMEM_RESPONDER -- requirements
Module: vscale_dmem_responder

Interface
REQ-001 Parameter WORDS, default 1024: backing-store depth in 32-bit words; power of two, 4 or more.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; aligned to WORDS*4.
REQ-003 Parameter WAIT_CYCLES, default 0: wait states inserted per access, range 0..15.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 dmem_en  in  1  address-phase request valid.
REQ-007 dmem_wen  in  1  address-phase write (1) / read (0).
REQ-008 dmem_size  in  3  access size: 0 byte, 1 half, 2 word, 3..7 illegal.
REQ-009 dmem_addr  in  32  address-phase byte address.
REQ-010 dmem_wdata_delayed  in  32  data-phase store data, byte/half-replicated by the initiator.
REQ-011 dmem_wait  out  1  data phase not complete; initiator holds all inputs.
REQ-012 dmem_rdata  out  32  data-phase aligned read word.
REQ-013 dmem_badmem_e  out  1  data-phase access error.

Function
REQ-014 Accept edge: rising edge with dmem_en=1 and dmem_wait=0; the block registers wen, size, addr and begins a data phase in the next cycle.
REQ-015 Pipelining: address phase N+1 is accepted on the same edge that completes data phase N; back-to-back accesses sustain one per cycle when WAIT_CYCLES=0.
REQ-016 FSM states: IDLE (no data phase), WAIT (data phase, wait count nonzero), DATA (data phase completing).
REQ-017 On accept, the wait counter loads WAIT_CYCLES; next state is WAIT if WAIT_CYCLES>0, else DATA.
REQ-018 In WAIT, dmem_wait=1 and the counter decrements by 1 each cycle; state goes to DATA when the counter reaches 0.
REQ-019 In DATA, dmem_wait=0; next state is WAIT or DATA on a new accept, else IDLE.
REQ-020 dmem_wait=0 in IDLE and DATA; it is a registered state decode, with no combinational path from inputs.
REQ-021 Bad access: registered addr outside [BASE_ADDR, BASE_ADDR+4*WORDS), or size 3..7, or half with addr[0]=1, or word with addr[1:0]!=0.
REQ-022 In DATA of a bad access: dmem_badmem_e=1, dmem_rdata=0, no store write; in all other cycles dmem_badmem_e=0.
REQ-023 Read in DATA: dmem_rdata = full word at index (addr-BASE_ADDR)>>2; the initiator performs lane extraction and extension.
REQ-024 Write in DATA: commit at the edge ending DATA, using byte enables: byte 1<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; dmem_rdata=0.
REQ-025 Write data for lane k is dmem_wdata_delayed[8k+7:8k], sampled only at the commit edge, never during WAIT.
REQ-026 RAW forwarding: a read accepted on the commit edge of a write to the same word returns the merged post-write word.
REQ-027 dmem_rdata is 0 in IDLE and WAIT.
REQ-028 Index arithmetic uses log2(WORDS) bits after the range check; no wrap-around aliasing.

Reset
REQ-029 While reset=1: state IDLE, counter 0, dmem_wait=0, dmem_rdata=0, dmem_badmem_e=0, any pending data phase is discarded without a write, and no accept occurs.
REQ-030 Backing-store contents are not cleared by reset; reset asserted mid-WAIT or mid-DATA aborts the access with no store update.
REQ-031 The first accept is possible on the first rising edge with reset=0.

Verification
REQ-032 WAIT_CYCLES=0: write word 0xDEADBEEF at 0x10, then read at 0x10 on the next edge -> read DATA rdata=0xDEADBEEF via forwarding; dmem_wait never 1.
REQ-033 Write byte, addr 0x13, wdata 0x5A5A5A5A, over word 0x11223344 -> later read of 0x10 returns 0x5A223344.
REQ-034 WAIT_CYCLES=3: read accepted at edge E -> dmem_wait=1 for cycles E+1..E+3, rdata valid at E+4, next accept at the end of E+4.
REQ-035 Half read at 0x21 or word write at 0x22 -> badmem_e=1 for one cycle, rdata=0, target word unchanged.
REQ-036 Read of BASE_ADDR+4*WORDS, or size=3 -> badmem_e=1; a valid access on the following edge completes normally.
REQ-037 WAIT_CYCLES=3, word write accepted, reset pulsed during the second wait cycle -> outputs zero, target word retains its old value, and a new accept is taken on the first edge after reset.
